// File: rtl/io_event_port_if.sv
// CPU-side port bundle of io_event_port.
//   ctl      : CPU out4 image (ack toggles, overflow-clear toggle, enables)
//   intr1/2  : level interrupt requests to CPU intr1/intr2
//   cpu_in1/2: captured payload bytes to CPU in1/in2
//   status   : {ovf2, ovf1, pend2, pend1}
// master = CPU side, slave = peripheral side.
interface io_event_port_if #(
  parameter int unsigned W = 8
);
  logic [W-1:0] ctl;
  logic         intr1;
  logic         intr2;
  logic [W-1:0] cpu_in1;
  logic [W-1:0] cpu_in2;
  logic [3:0]   status;

  modport master (
    output ctl,
    input  intr1, intr2, cpu_in1, cpu_in2, status
  );

  modport slave (
    input  ctl,
    output intr1, intr2, cpu_in1, cpu_in2, status
  );
endinterface

// File: rtl/io_event_port.sv
// Two-channel external event port: synchronises asynchronous event lines,
// captures one payload byte per event and raises level interrupts that the
// CPU acknowledges by toggling bits of its out4 register.
//   clk      : system clock shared with the CPU
//   reset    : asynchronous, active-low
//   ev1/ev2  : asynchronous event lines, rising edge = event
//   d1/d2    : payloads, stable for SYNC+1 cycles after the event rises
//   bus      : CPU-side bundle (ctl in; intr1/2, cpu_in1/2, status out)
// ctl bits: 0 ack1 toggle, 1 ack2 toggle, 2 overflow-clear toggle,
//           4 enable1, 5 enable2; the rest are ignored.
module io_event_port #(
  parameter int unsigned W    = 8,
  parameter int unsigned SYNC = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ev1,
  input  logic           ev2,
  input  logic [W-1:0]   d1,
  input  logic [W-1:0]   d2,
  io_event_port_if.slave bus
);

  localparam int unsigned NCH         = 2;
  localparam int unsigned OVF_CLR_BIT = 2;
  localparam int unsigned EN_BIT0     = 4;
  localparam int unsigned TOGGLE_W    = 3;

  logic [NCH-1:0]      ev_in;
  logic [W-1:0]        d_in [NCH];
  logic [TOGGLE_W-1:0] ctl_prev;
  logic                ovf_clr;

  logic [NCH-1:0]      rise;
  logic [NCH-1:0]      ack;
  logic [NCH-1:0]      en;
  logic [NCH-1:0]      capture;
  logic [NCH-1:0]      ovf_set;
  logic [NCH-1:0]      pend;
  logic [NCH-1:0]      ovf;
  logic [W-1:0]        hold [NCH];

  assign ev_in   = {ev2, ev1};
  assign d_in[0] = d1;
  assign d_in[1] = d2;

  // Previous image of the toggle bits; a change is a one-cycle command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctl_prev <= '0;
    end else begin
      ctl_prev <= bus.ctl[TOGGLE_W-1:0];
    end
  end

  assign ovf_clr = bus.ctl[OVF_CLR_BIT] ^ ctl_prev[OVF_CLR_BIT];

  // Per-channel synchroniser, edge detect, pending flag, payload and overflow.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [SYNC-1:0] sync_q;
    logic            hist_q;
    logic            pend_q;
    logic            ovf_q;
    logic [W-1:0]    hold_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_q <= '0;
        hist_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC-2:0], ev_in[g]};
        hist_q <= sync_q[SYNC-1];
      end
    end

    assign rise[g] = sync_q[SYNC-1] & ~hist_q;
    assign ack[g]  = bus.ctl[g] ^ ctl_prev[g];
    assign en[g]   = bus.ctl[EN_BIT0 + g];

    // An ack in the same cycle frees the slot for the new event.
    assign capture[g] = rise[g] & (~pend_q | ack[g]);
    assign ovf_set[g] = rise[g] & pend_q & ~ack[g];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        pend_q <= 1'b0;
        hold_q <= '0;
      end else if (capture[g]) begin
        pend_q <= 1'b1;
        hold_q <= d_in[g];
      end else if (ack[g]) begin
        pend_q <= 1'b0;
      end
    end

    // Sticky overflow; a new overflow beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        ovf_q <= 1'b0;
      end else if (ovf_set[g]) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end

    assign pend[g] = pend_q;
    assign ovf[g]  = ovf_q;
    assign hold[g] = hold_q;
  end

  // Enables gate only the request lines, so re-enabling is immediate.
  assign bus.intr1   = pend[0] & en[0];
  assign bus.intr2   = pend[1] & en[1];
  assign bus.cpu_in1 = hold[0];
  assign bus.cpu_in2 = hold[1];
  assign bus.status  = {ovf[1], ovf[0], pend[1], pend[0]};

  logic unused_ctl;
  assign unused_ctl = ^{bus.ctl[W-1:EN_BIT0+NCH], bus.ctl[EN_BIT0-1:TOGGLE_W]};

endmodule
